// File: rtl/itcm_loader.sv
// itcm_loader: instruction TCM with a byte-serial boot loader.
// The loader assembles little-endian bytes into words, fills the memory, then
// raises cpu_en. The fetch port is combinational and only live once loading is done.
// Optional feature macro: ITCM_CHKSUM_EN. When it is defined, a trailing checksum
// byte follows the last data byte. The 8-bit sum of all data bytes plus that
// checksum byte must be zero.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module itcm_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int PC_W   = `PC_WIDTH,
    parameter int WORD_W = `WORD_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded,
    output logic              cpu_en,
    input  logic              rd_insn_en,
    input  logic [PC_W-1:0]   pc,
    output logic [WORD_W-1:0] insn
);

`ifdef ITCM_CHKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;
`endif

    state_t              state, state_nx;
    logic [ADDR_W:0]     wptr;
    logic [1:0]          byte_cnt;
    logic [WORD_W-1:0]   shreg;
    logic [WORD_W-1:0]   asm_word;
    logic [WORD_W-1:0]   mem [DEPTH];
    logic                start_load, accept, wr_word, overflow, pc_in_range;
    logic                unused_pc;
`ifdef ITCM_CHKSUM_EN
    logic [7:0]          sum;
    logic                in_chk;
    assign in_chk = (state == S_CHK);
`endif

    // load_ready is a pure decode of the state register.
`ifdef ITCM_CHKSUM_EN
    assign load_ready = (state == S_LOAD) || in_chk;
`else
    assign load_ready = (state == S_LOAD);
`endif
    assign accept     = load_valid && load_ready;
    assign start_load = load_start &&
                        (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign wr_word    = accept && (state == S_LOAD) && (byte_cnt == 2'd3 || load_last);
    assign overflow   = wr_word && (wptr == (ADDR_W+1)'(DEPTH));
    assign words_loaded = wptr;

    // Merge the incoming byte into the bytes already collected.
    // The unfilled upper bytes of the shift register are always zero.
    always_comb begin
        asm_word = shreg;
        asm_word[{byte_cnt, 3'b000} +: 8] = load_byte;
    end

    // Next-state logic for the loader sequencing.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (load_start) state_nx = S_LOAD;
            S_LOAD: begin
                if (overflow)
                    state_nx = S_ERR;
`ifdef ITCM_CHKSUM_EN
                else if (wr_word && load_last)
                    state_nx = S_CHK;
`else
                else if (wr_word && load_last)
                    state_nx = S_DONE;
`endif
            end
`ifdef ITCM_CHKSUM_EN
            S_CHK: if (accept) state_nx = (8'(sum + load_byte) == 8'h00) ? S_DONE : S_ERR;
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    // State register and the registered run-enable and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cpu_en   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state  <= state_nx;
            cpu_en <= (state_nx == S_DONE);
            if (start_load)
                load_err <= 1'b0;
            else if (state_nx == S_ERR && state != S_ERR)
                load_err <= 1'b1;
        end
    end

    // Byte assembly, word pointer and running sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
`ifdef ITCM_CHKSUM_EN
            sum      <= '0;
`endif
        end else if (start_load) begin
            wptr     <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
`ifdef ITCM_CHKSUM_EN
            sum      <= '0;
`endif
        end else if (accept && state == S_LOAD) begin
`ifdef ITCM_CHKSUM_EN
            sum <= sum + load_byte;
`endif
            if (wr_word) begin
                byte_cnt <= '0;
                shreg    <= '0;
                if (!overflow) wptr <= wptr + (ADDR_W+1)'(1);
            end else begin
                byte_cnt <= byte_cnt + 2'd1;
                shreg[{byte_cnt, 3'b000} +: 8] <= load_byte;
            end
        end
    end

    // Memory write port. The array contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_word && !overflow) mem[wptr[ADDR_W-1:0]] <= asm_word;
    end

    // The fetch is zero latency and gated by DONE.
    // Byte offset bits are ignored, and any address above the array reads zero.
    assign pc_in_range = ((pc >> (ADDR_W + 2)) == '0);
    assign unused_pc   = ^pc[1:0];
    assign insn = (rd_insn_en && state == S_DONE && pc_in_range) ?
                  mem[pc[ADDR_W+1:2]] : '0;

endmodule

// File: tb/tb_itcm_loader.sv
// Randomized self-checking bench for itcm_loader.
// The reference model tracks the download at the byte and word level.
`timescale 1ns/1ps
module tb_itcm_loader;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
    localparam int PC_W   = 32;

    logic              clk = 0, rst_n = 0;
    logic              load_start = 0, load_valid = 0, load_last = 0, rd_insn_en = 0;
    logic [7:0]        load_byte = 0;
    logic [PC_W-1:0]   pc = 0;
    logic              load_ready, load_err, cpu_en;
    logic [ADDR_W:0]   words_loaded;
    logic [31:0]       insn;

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    itcm_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PC_W(PC_W), .WORD_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
        .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready),
        .load_err(load_err), .words_loaded(words_loaded), .cpu_en(cpu_en),
        .rd_insn_en(rd_insn_en), .pc(pc), .insn(insn));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the download phase, the pending bytes and the loaded image.
    bit          m_load, m_chk, m_done, m_err;
    int          m_wl;
    logic [7:0]  pend[$];
    logic [7:0]  m_sum;
    logic [31:0] m_img[int];

    initial forever begin
        logic [31:0] w;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_load = 0; m_chk = 0; m_done = 0; m_err = 0; m_wl = 0;
            pend.delete(); m_sum = 0;
        end else if (load_start && !m_load && !m_chk) begin
            m_load = 1; m_chk = 0; m_done = 0; m_err = 0; m_wl = 0;
            pend.delete(); m_sum = 0; m_img.delete();
        end else if (load_valid && (m_load || m_chk)) begin
            if (m_chk) begin
                m_chk = 0;
                if (8'(m_sum + load_byte) == 8'h00) m_done = 1; else m_err = 1;
            end else begin
                pend.push_back(load_byte);
                m_sum = m_sum + load_byte;
                if (pend.size() == 4 || load_last) begin
                    w = 0;
                    foreach (pend[i]) w = w | (32'(pend[i]) << (8 * i));
                    pend.delete();
                    if (m_wl == DEPTH) begin
                        m_err = 1; m_load = 0;
                    end else begin
                        m_img[m_wl] = w;
                        m_wl++;
                        if (load_last) begin
                            m_load = 0;
`ifdef ITCM_CHKSUM_EN
                            m_chk = 1;
`else
                            m_done = 1;
`endif
                        end
                    end
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    initial forever begin
        int idx;
        @(negedge clk);
        check("load_ready", 32'(load_ready), 32'(m_load || m_chk));
        check("load_err", 32'(load_err), 32'(m_err));
        check("words_loaded", 32'(words_loaded), 32'(m_wl));
        check("cpu_en", 32'(cpu_en), 32'(m_done));
        if (m_done && rd_insn_en) begin
            if ((pc >> (ADDR_W + 2)) != 0)
                check("insn_oor", insn, 32'h0);
            else begin
                idx = int'(pc[ADDR_W+1:2]);
                if (m_img.exists(idx)) check("insn", insn, m_img[idx]);
            end
        end else
            check("insn_gated", insn, 32'h0);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start();
        load_start = 1; tick(); load_start = 0;
    endtask

    task automatic push(input logic [7:0] b, input bit last, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        load_valid = 1; load_byte = b; load_last = last;
        tick();
        load_valid = 0; load_last = 0; load_byte = 8'($urandom);
    endtask

    task automatic rand_fetch(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            rd_insn_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 7) == 0)
                pc = 32'h1000 + 32'($urandom_range(0, 4095));
            else if (m_wl > 0)
                pc = {20'h0, 10'($urandom_range(0, m_wl - 1)), 2'($urandom)};
            tick();
        end
        rd_insn_en = 0;
    endtask

    initial begin
        logic [7:0] img1 [8];
        img1 = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

        // Reset values.
        #2;
        check("rst_ready", 32'(load_ready), 32'h0);
        check("rst_cpu_en", 32'(cpu_en), 32'h0);
        check("rst_words", 32'(words_loaded), 32'h0);
        tick(); rst_n = 1; tick();

        // Two-word image.
        start();
        for (int i = 0; i < 8; i++) push(img1[i], i == 7, 0);
`ifndef ITCM_CHKSUM_EN
        check("t1_words", 32'(words_loaded), 32'd2);
        check("t1_cpu_en", 32'(cpu_en), 32'h1);
        rd_insn_en = 1; pc = 32'h0; #1;
        check("t1_pc0", insn, 32'h00000513);
        pc = 32'h6; #1;
        check("t1_pc6", insn, 32'h00100093);
        pc = 32'h1000; #1;
        check("t1_pc_oor", insn, 32'h0);
        rd_insn_en = 0; pc = 32'h0; #1;
        check("t1_rd_off", insn, 32'h0);
        // Bytes offered while the loader is not ready are ignored.
        for (int i = 0; i < 4; i++) push(8'($urandom), 1, 0);
        check("t1_ignored", 32'(words_loaded), 32'd2);

        // Reload from DONE with a partial word.
        rd_insn_en = 1;
        start();
        check("t5_cpu_en", 32'(cpu_en), 32'h0);
        check("t5_words", 32'(words_loaded), 32'h0);
        check("t5_insn", insn, 32'h0);
        rd_insn_en = 0;
        push(8'hAA, 0, 0); push(8'hBB, 0, 1); push(8'hCC, 1, 1);
        check("t2_words", 32'(words_loaded), 32'd1);
        rd_insn_en = 1; pc = 32'h0; #1;
        check("t2_word", insn, 32'h00CCBBAA);
        rd_insn_en = 0;
`endif

`ifdef ITCM_CHKSUM_EN
        // A checksum byte that brings the sum to zero, then one that does not.
        start();
        for (int i = 0; i < 4; i++) push(8'(i + 1), i == 3, 0);
        push(8'hF6, 0, 0);
        check("chk_ok_cpu_en", 32'(cpu_en), 32'h1);
        start();
        for (int i = 0; i < 4; i++) push(8'(i + 1), i == 3, 0);
        push(8'hFB, 1, 0);
        check("chk_bad_err", 32'(load_err), 32'h1);
        check("chk_bad_cpu_en", 32'(cpu_en), 32'h0);
`endif

        // Randomized images.
        for (int it = 0; it < 15; it++) begin
            int n;
            n = $urandom_range(1, 40);
            start();
            for (int i = 0; i < n; i++) push(8'($urandom), i == n - 1, 1);
`ifdef ITCM_CHKSUM_EN
            push(-m_sum, 0, 1);
`endif
            rand_fetch(20);
        end

        // Reset in the middle of a download.
        start();
        for (int i = 0; i < 6; i++) push(8'($urandom), 0, 0);
        #1 rst_n = 0; #1;
        check("t4_ready", 32'(load_ready), 32'h0);
        check("t4_words", 32'(words_loaded), 32'h0);
        check("t4_err", 32'(load_err), 32'h0);
        check("t4_cpu_en", 32'(cpu_en), 32'h0);
        tick(); rst_n = 1; tick();
        start();
        for (int i = 0; i < 8; i++) push(8'($urandom), i == 7, 1);
`ifdef ITCM_CHKSUM_EN
        push(-m_sum, 0, 0);
`endif
        check("t4_restart_words", 32'(words_loaded), 32'd2);
        rand_fetch(10);

        // Overflow: one byte more than the array can hold.
        start();
        for (int i = 0; i < 4 * DEPTH + 1; i++) push(8'($urandom), i == 4 * DEPTH, 0);
        check("t3_err", 32'(load_err), 32'h1);
        check("t3_cpu_en", 32'(cpu_en), 32'h0);
        check("t3_ready", 32'(load_ready), 32'h0);
        check("t3_words", 32'(words_loaded), 32'(DEPTH));
        start();
        check("t3_err_clr", 32'(load_err), 32'h0);
        push(8'h11, 1, 0);
`ifdef ITCM_CHKSUM_EN
        push(8'hEF, 0, 0);
`endif
        rand_fetch(5);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
